// File: rtl/dm_mem_port_if.sv
// dm_mem_port_if
//   Groups the request/response signals between the load/store controller
//   (master) and the data-memory storage stage (slave).
//   Signals:
//     req               request strobe, sampled by the slave only when idle
//     mem_w             1 = store, 0 = load
//     Addr_in           byte address (word index above bit 1, lane in [1:0])
//     wea_mem           low-lane-aligned byte enables
//     Data_write_to_dm  low-lane-aligned store data
//     Data_read_from_dm raw 32-bit word returned by a load
//     busy              request in flight
//     ready             one-cycle completion pulse
//     err               misalignment flag, present only when DM_ERR_EN is defined
interface dm_mem_port_if;
  logic        req;
  logic        mem_w;
  logic [31:0] Addr_in;
  logic [3:0]  wea_mem;
  logic [31:0] Data_write_to_dm;
  logic [31:0] Data_read_from_dm;
  logic        busy;
  logic        ready;
`ifdef DM_ERR_EN
  logic        err;
`endif

  modport master (
    output req, mem_w, Addr_in, wea_mem, Data_write_to_dm,
    input  Data_read_from_dm, busy, ready
`ifdef DM_ERR_EN
    , input err
`endif
  );

  modport slave (
    input  req, mem_w, Addr_in, wea_mem, Data_write_to_dm,
    output Data_read_from_dm, busy, ready
`ifdef DM_ERR_EN
    , output err
`endif
  );
endinterface

// File: rtl/dm_mem_port.sv
// dm_mem_port
//   Data-memory storage stage behind the load/store controller. A request is
//   latched when idle, waits WAIT_STATES cycles, then performs the access:
//   stores move the low-lane-aligned data/enables into the addressed byte
//   lanes; loads return the whole raw word (lane extraction is upstream).
//   Optional macro: DM_ERR_EN adds the err output, which flags misaligned
//   half/word accesses and suppresses misaligned store writes.
//   Ports:
//     clk   system clock, rising edge
//     rstn  asynchronous active-low reset (storage is not cleared)
//     bus   dm_mem_port_if.slave request/response bundle
//   Parameters:
//     ADDR_WIDTH   word-index width, depth is 2**ADDR_WIDTH words
//     WAIT_STATES  extra cycles before each access, 0..15
module dm_mem_port #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input logic          clk,
  input logic          rstn,
  dm_mem_port_if.slave bus
);

  localparam int         DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                  state, state_next;
  logic [3:0]              cnt, cnt_next;
  logic                    accept, complete;

  logic                    lat_w;
  logic [ADDR_WIDTH+1:0]   lat_addr;
  logic [3:0]              lat_wea;
  logic [31:0]             lat_data;

  logic                    busy_q, ready_q;
  logic [31:0]             rdata;

  logic [31:0]             mem [0:DEPTH-1];

  logic [ADDR_WIDTH-1:0]   idx;
  logic [1:0]              sh;
  logic [3:0]              sh_wea;
  logic [31:0]             sh_data;
  logic [3:0]              lane_en;

  assign idx     = lat_addr[ADDR_WIDTH+1:2];
  assign sh      = lat_addr[1:0];
  // Enables past lane 3 fall off the top of the 4-bit vector.
  assign sh_wea  = lat_wea << sh;
  assign sh_data = lat_data << {sh, 3'b000};

`ifdef DM_ERR_EN
  logic misaligned;
  logic err_q;

  assign misaligned = ((lat_wea == 4'b0011) && lat_addr[0]) ||
                      ((lat_wea == 4'b1111) && (lat_addr[1:0] != 2'b00));
  assign lane_en    = misaligned ? 4'b0000 : sh_wea;
  assign bus.err    = err_q;
`else
  assign lane_en    = sh_wea;
`endif

  // Next-state logic: accept in IDLE, count down wait states in BUSY and
  // complete the access on the edge where the counter is already zero.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req) begin
          accept     = 1'b1;
          cnt_next   = WS_LOAD;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (cnt != 4'd0) begin
          cnt_next = cnt - 4'd1;
        end else begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
    endcase
  end

  // State, request latch and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      rdata    <= 32'd0;
      lat_w    <= 1'b0;
      lat_addr <= '0;
      lat_wea  <= 4'd0;
      lat_data <= 32'd0;
`ifdef DM_ERR_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      ready_q <= complete;
`ifdef DM_ERR_EN
      err_q   <= complete & misaligned;
`endif
      if (accept) begin
        lat_w    <= bus.mem_w;
        lat_addr <= bus.Addr_in[ADDR_WIDTH+1:0];
        lat_wea  <= bus.wea_mem;
        lat_data <= bus.Data_write_to_dm;
        busy_q   <= 1'b1;
      end else if (complete) begin
        busy_q   <= 1'b0;
      end
      if (complete && !lat_w) begin
        rdata <= mem[idx];
      end
    end
  end

  // Storage array has no reset; only enabled lanes of a completing store change.
  always_ff @(posedge clk) begin
    if (complete && lat_w) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) begin
          mem[idx][8*i +: 8] <= sh_data[8*i +: 8];
        end
      end
    end
  end

  assign bus.busy              = busy_q;
  assign bus.ready             = ready_q;
  assign bus.Data_read_from_dm = rdata;

endmodule

// File: doc/dm_mem_port.md
Name: dm_mem_port

Overview:
- Data-memory storage stage directly downstream of the load/store controller.
- Consumes low-lane-aligned write data, byte-write enables and byte address from the controller.
- Shifts data and enables into the addressed byte lanes, then performs the access after programmable wait states.
- Returns the raw 32-bit word plus a one-cycle ready pulse; the controller's read path does lane extraction and extension on that word.

Parameters:
- ADDR_WIDTH, 10: word-index width; storage depth is 2**ADDR_WIDTH 32-bit words.
- WAIT_STATES, 1: extra cycles inserted before each access; legal range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- req  in  1  access request; sampled only in IDLE.
- mem_w  in  1  1 = store, 0 = load; latched with req.
- Addr_in  in  32  byte address; uses bits [ADDR_WIDTH+1:2] as word index and [1:0] as lane offset.
- wea_mem  in  4  low-lane-aligned byte enables (1111 word, 0011 half, 0001 byte).
- Data_write_to_dm  in  32  low-lane-aligned store data.
- Data_read_from_dm  out  32  raw word read; registered.
- busy  out  1  registered; high while a request is in flight.
- ready  out  1  registered one-cycle completion pulse.
- err  out  1  registered misalignment flag; exists only with DM_ERR_EN.

Behaviour:
- Reset (rstn low, asynchronous): state IDLE, counter 0, busy 0, ready 0, Data_read_from_dm 0, err 0. Storage contents are not cleared.
- Latched fields: Addr_in, mem_w, wea_mem and Data_write_to_dm are captured on the accepting edge. Later input changes have no effect on the in-flight access.
- FSM states: IDLE and BUSY.
- IDLE:
  - req=1 at an edge: latch the fields, load the counter with WAIT_STATES, go to BUSY, busy<=1.
  - req=0: stay in IDLE.
- BUSY, counter != 0: decrement the counter, stay in BUSY.
- BUSY, counter == 0: perform the access on this edge, set ready<=1, busy<=0, go to IDLE.
- ready is high for exactly one cycle, then 0.
- Latency: req sampled at edge k → ready high in the cycle after edge k+WAIT_STATES+1. With WAIT_STATES=0 that is the cycle after edge k+1.
- Back-to-back requests: req high in the cycle where ready is high (state IDLE) is accepted at the next edge.
- Lane shifting: sh = Addr_in[1:0].
  - Shifted enables = (wea_mem << sh) truncated to 4 bits; bits shifted past lane 3 are dropped.
  - Shifted data = Data_write_to_dm << 8*sh.
- Store: for each lane i with shifted enable set, mem[idx][8i+7:8i] <= shifted data lane i. Other lanes are unchanged. Data_read_from_dm holds its previous value.
- Load: Data_read_from_dm <= mem[idx] (whole word, no shift). The value is held until the next load completes.
- Store with wea_mem=0000: no lanes written; ready still pulses.
- Address wrap: address bits above ADDR_WIDTH+1 are ignored, so the index wraps modulo depth.
- req held high continuously: a new access starts every WAIT_STATES+2 cycles.

Optional Feature:
- Macro DM_ERR_EN.
- Defined:
  - misaligned = (wea_mem==0011 and Addr_in[0]=1) or (wea_mem==1111 and Addr_in[1:0]!=00).
  - err<=misaligned at the completing edge and pulses together with ready; otherwise err=0.
  - Misaligned stores write no lanes.
  - Misaligned loads still return the word.
- Not defined: err port and its logic are absent; misaligned stores write the truncated shifted lanes as described above.

Test Plan:
- Reset, WAIT_STATES=1: store word 0x11223344 at 0x0, then load 0x0 → ready pulses 3 cycles after each accept edge; read returns 0x11223344.
- Store byte 0x000000AB with wea=0001 at addr 0x6, then load 0x4 → word 0x00AB0000 given prior contents 0.
- Store half 0x0000BEEF with wea=0011 at 0x2 over 0x11223344 at word 0 → load 0x0 returns 0xBEEF3344.
- Assert rstn low while in BUSY with a pending store to 0x8 → busy=0, ready=0 immediately; stored word unchanged; next req is accepted normally.
- req held high for 4 loads at 0x0,0x4,0x8,0xC (WAIT_STATES=0) → ready pulses every 2 cycles with the correct words in order.
- With DM_ERR_EN: store half at 0x3 → err=1 with ready, memory unchanged. Without the macro → lane 3 receives the low byte only.
